// File: rtl/input_debounce_pkg.sv
// Shared types and defaults for input_debounce and its downstream edge_detect bench.
package input_debounce_pkg;

   localparam int unsigned DEF_STABLE_COUNT = 4;
   localparam int unsigned DEF_CNT_WIDTH    = 3;

   typedef enum logic [1:0] {
      StStableLow  = 2'b00,
      StWaitHigh   = 2'b01,
      StStableHigh = 2'b11,
      StWaitLow    = 2'b10
   } deb_state_e;

   function automatic logic is_wait(input deb_state_e state);
      return (state == StWaitHigh) || (state == StWaitLow);
   endfunction

endpackage

// File: rtl/input_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; only built with INPUT_DEBOUNCE_SYNC_EN.
`ifdef INPUT_DEBOUNCE_SYNC_EN
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`endif

// File: rtl/input_debounce.sv
// Debounces a raw one-bit input into a registered level plus a qualification-busy flag.
// Define INPUT_DEBOUNCE_SYNC_EN to insert a 2-FF synchroniser ahead of the FSM.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
   parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic busy
);

   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

   logic                 w_sync_in;
   deb_state_e           r_state;
   deb_state_e           w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 r_out;
   logic                 w_out_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;

`ifdef INPUT_DEBOUNCE_SYNC_EN
   sync_2ff u_sync (
      .clock (clock),
      .reset (reset),
      .i_d   (in),
      .o_q   (w_sync_in)
   );
`else
   assign w_sync_in = in;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= StStableLow;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // A contrary sample during qualification drops straight back to the prior stable state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      case (r_state)
         StStableLow: begin
            if (w_sync_in) begin
               w_state_nxt = StWaitHigh;
               w_cnt_nxt   = CntOne;
            end
         end
         StWaitHigh: begin
            if (!w_sync_in) begin
               w_state_nxt = StStableLow;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CntLast) begin
               w_state_nxt = StStableHigh;
               w_out_nxt   = 1'b1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CntOne;
            end
         end
         StStableHigh: begin
            if (!w_sync_in) begin
               w_state_nxt = StWaitLow;
               w_cnt_nxt   = CntOne;
            end
         end
         StWaitLow: begin
            if (w_sync_in) begin
               w_state_nxt = StStableHigh;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CntLast) begin
               w_state_nxt = StStableLow;
               w_out_nxt   = 1'b0;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CntOne;
            end
         end
         default: begin
            w_state_nxt = StStableLow;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
         end
      endcase
      w_busy_nxt = is_wait(w_state_nxt);
   end

   assign out  = r_out;
   assign busy = r_busy;

endmodule
